// File: rtl/dlbf_data_ctrl_pkg.sv
// Shared widths, state encoding and config check for the DLBF data-channel run sequencer.
package dlbf_data_ctrl_pkg;

  localparam int CFG_BS_W    = 12;
  localparam int CFG_NITER_W = 12;
  localparam int CFG_ADDR_W  = 16;
  localparam int CFG_REP_W   = 8;
  localparam int TMR_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_ARM   = 3'd2,
    ST_RUN   = 3'd3,
    ST_END   = 3'd4,
    ST_ABORT = 3'd5
  } run_state_t;

  // A run needs a nonzero block length, a nonzero wrap point and at least one channel.
  function automatic logic cfg_ok(input logic [CFG_BS_W-1:0]   bs,
                                  input logic [CFG_ADDR_W-1:0] addr,
                                  input logic                  en_any);
    return (bs != '0) && (addr != '0) && en_any;
  endfunction

endpackage

// File: rtl/dlbf_data_run_ctrl_if.sv
// Control bus between the run sequencer (master) and the bank of data channels (slave).
interface dlbf_data_run_ctrl_if #(
  parameter int NUM_CH = 4
);
  import dlbf_data_ctrl_pkg::*;

  logic [NUM_CH-1:0]      ch_go;
  logic [NUM_CH-1:0]      ch_rst;
  logic [NUM_CH-1:0]      ch_done;
  logic [CFG_BS_W-1:0]    block_size;
  logic [CFG_NITER_W-1:0] niter;
  logic [CFG_ADDR_W-1:0]  rollover_addr;

  modport master (
    output ch_go, ch_rst, block_size, niter, rollover_addr,
    input  ch_done
  );

  modport slave (
    input  ch_go, ch_rst, block_size, niter, rollover_addr,
    output ch_done
  );

endinterface

// File: rtl/dlbf_data_cycle_timer.sv
// Loadable down-counter with a zero flag; times the flush, settle and abort waits.
module dlbf_data_cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/dlbf_data_run_ctrl.sv
// Run sequencer for the DLBF data channels: latches a run config, flushes, arms and runs
// the enabled channels, collects their done flags and repeats runs until the sequence ends.
module dlbf_data_run_ctrl
  import dlbf_data_ctrl_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int RST_CYCLES    = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT_W     = 24
) (
  input  logic                   m_axis_clk,
  input  logic                   m_axis_rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CFG_BS_W-1:0]    cfg_block_size,
  input  logic [CFG_NITER_W-1:0] cfg_niter,
  input  logic [CFG_ADDR_W-1:0]  cfg_rollover_addr,
  input  logic [NUM_CH-1:0]      cfg_ch_en,
  input  logic [CFG_REP_W-1:0]   cfg_repeat,
  input  logic [TIMEOUT_W-1:0]   cfg_timeout,
  dlbf_data_run_ctrl_if.master   ch,
  output logic                   busy,
  output logic                   run_done,
  output logic                   seq_done,
  output logic [CFG_REP_W-1:0]   run_count,
  output logic                   err_cfg,
  output logic                   err_timeout
);

  run_state_t state_q, state_nxt;

  logic [NUM_CH-1:0]      en_q;
  logic [NUM_CH-1:0]      done_sticky_q;
  logic [CFG_BS_W-1:0]    block_size_q;
  logic [CFG_NITER_W-1:0] niter_q;
  logic [CFG_ADDR_W-1:0]  rollover_q;
  logic [CFG_REP_W-1:0]   rep_q;
  logic [TIMEOUT_W-1:0]   timeout_q;
  logic [TIMEOUT_W-1:0]   wd_q;
  logic [TIMEOUT_W-1:0]   wd_inc;
  logic [CFG_REP_W-1:0]   run_count_q;
  logic                   err_cfg_q;
  logic                   err_timeout_q;

  logic [NUM_CH-1:0] ch_go_q, ch_go_nxt;
  logic [NUM_CH-1:0] ch_rst_q, ch_rst_nxt;
  logic              busy_q, busy_nxt;
  logic              run_done_q, run_done_nxt;
  logic              seq_done_q, seq_done_nxt;

  logic              start_ok;
  logic              start_bad;
  logic              free_run;
  logic              all_done;
  logic              wd_fire;
  logic              seq_last;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_zero;

  assign free_run = (niter_q == '0);
  assign all_done = &(done_sticky_q | ~en_q);
  assign wd_inc   = (&wd_q) ? wd_q : wd_q + 1'b1;
  assign wd_fire  = (state_q == ST_RUN) && !abort && !free_run &&
                    (timeout_q != '0) && (wd_inc == timeout_q);
  assign seq_last = (rep_q != '0) && ((run_count_q + 8'd1) == rep_q);

  dlbf_data_cycle_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (m_axis_clk),
    .rst      (m_axis_rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge m_axis_clk or posedge m_axis_rst) begin
    if (m_axis_rst) begin
      state_q    <= ST_IDLE;
      ch_go_q    <= '0;
      ch_rst_q   <= '1;
      busy_q     <= 1'b0;
      run_done_q <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      ch_go_q    <= ch_go_nxt;
      ch_rst_q   <= ch_rst_nxt;
      busy_q     <= busy_nxt;
      run_done_q <= run_done_nxt;
      seq_done_q <= seq_done_nxt;
    end
  end

  // Abort outranks every other exit; outputs are derived from the next state so they register with it.
  always_comb begin
    state_nxt    = state_q;
    start_ok     = 1'b0;
    start_bad    = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = TMR_W'(RST_CYCLES - 1);
    ch_go_nxt    = '0;
    ch_rst_nxt   = '1;
    run_done_nxt = 1'b0;
    seq_done_nxt = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok(cfg_block_size, cfg_rollover_addr, |cfg_ch_en)) begin
            start_ok  = 1'b1;
            state_nxt = ST_FLUSH;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (abort)         state_nxt = ST_ABORT;
        else if (tmr_zero) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        if (abort)         state_nxt = ST_ABORT;
        else if (tmr_zero) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (abort || wd_fire)           state_nxt = ST_ABORT;
        else if (!free_run && all_done) state_nxt = ST_END;
      end
      ST_END: begin
        if (abort)           state_nxt = ST_ABORT;
        else if (seq_done_q) state_nxt = ST_IDLE;
        else                 state_nxt = ST_FLUSH;
      end
      ST_ABORT: begin
        if (tmr_zero) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if ((state_nxt != state_q) &&
        ((state_nxt == ST_FLUSH) || (state_nxt == ST_ARM) || (state_nxt == ST_ABORT))) begin
      tmr_load = 1'b1;
      if (state_nxt == ST_ARM) tmr_val = TMR_W'(SETTLE_CYCLES - 1);
    end

    busy_nxt = (state_nxt != ST_IDLE);
    case (state_nxt)
      ST_ARM: ch_rst_nxt = ~en_q;
      ST_RUN: begin
        ch_go_nxt  = en_q;
        ch_rst_nxt = ~en_q;
      end
      ST_END: begin
        ch_rst_nxt   = ~en_q;
        run_done_nxt = 1'b1;
        seq_done_nxt = seq_last;
      end
      default: ;
    endcase
  end

  // Config, run counter, error flags, done collection and the RUN watchdog.
  always_ff @(posedge m_axis_clk or posedge m_axis_rst) begin
    if (m_axis_rst) begin
      en_q          <= '0;
      block_size_q  <= '0;
      niter_q       <= '0;
      rollover_q    <= '0;
      rep_q         <= '0;
      timeout_q     <= '0;
      run_count_q   <= '0;
      err_cfg_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      done_sticky_q <= '0;
      wd_q          <= '0;
    end else begin
      if (start_ok) begin
        en_q          <= cfg_ch_en;
        block_size_q  <= cfg_block_size;
        niter_q       <= cfg_niter;
        rollover_q    <= cfg_rollover_addr;
        rep_q         <= cfg_repeat;
        timeout_q     <= cfg_timeout;
        run_count_q   <= '0;
        err_cfg_q     <= 1'b0;
        err_timeout_q <= 1'b0;
      end
      if (start_bad) err_cfg_q <= 1'b1;
      if (wd_fire)   err_timeout_q <= 1'b1;
      if (state_nxt == ST_END) run_count_q <= run_count_q + 1'b1;

      if (state_q == ST_RUN) begin
        done_sticky_q <= done_sticky_q | (ch.ch_done & en_q);
        wd_q          <= wd_inc;
      end else begin
        done_sticky_q <= '0;
        wd_q          <= '0;
      end
    end
  end

  assign ch.ch_go         = ch_go_q;
  assign ch.ch_rst        = ch_rst_q;
  assign ch.block_size    = block_size_q;
  assign ch.niter         = niter_q;
  assign ch.rollover_addr = rollover_q;

  assign busy        = busy_q;
  assign run_done    = run_done_q;
  assign seq_done    = seq_done_q;
  assign run_count   = run_count_q;
  assign err_cfg     = err_cfg_q;
  assign err_timeout = err_timeout_q;

endmodule
